// File: rtl/alu_sequencer.sv
// Accumulator sequencer that drives an external registered ALU.
// It handles load/op commands and a valid/ready result handshake.
// Optional result flags are enabled with the macro ALU_SEQ_FLAGS_EN.
`timescale 1ns/1ps
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_load,
    input  logic [2:0] in_op,
    input  logic [7:0] in_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_m,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_x,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] acc,
    output logic [7:0] op_count,
    output logic       zero_flag,
    output logic       neg_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] op_count_q, op_count_d;
    logic [2:0] op_q, op_d;
    logic [7:0] m_q, m_d;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;
        op_d        = op_q;
        m_d         = m_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_load) begin
                        acc_d       = in_data;
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        op_d    = in_op;
                        m_d     = in_data;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                state_d = CAPT;
            end
            // The ALU registered its result at the end of EXEC, so alu_x is valid here.
            CAPT: begin
                acc_d       = alu_x;
                out_data_d  = alu_x;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            op_count_q  <= 8'h00;
            op_q        <= 3'd0;
            m_q         <= 8'h00;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
            op_q        <= op_d;
            m_q         <= m_d;
        end
    end

    // op_q/m_q only change on accept, so the ALU inputs hold outside EXEC.
    assign in_ready  = (state_q == IDLE);
    assign alu_a     = acc_q;
    assign alu_m     = m_q;
    assign alu_op    = op_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign acc       = acc_q;
    assign op_count  = op_count_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic       zero_q, neg_q;
    logic       wr_en;
    logic [7:0] wr_val;

    assign wr_en  = ((state_q == IDLE) && in_valid && in_load) || (state_q == CAPT);
    assign wr_val = (state_q == CAPT) ? alu_x : in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (wr_en) begin
            zero_q <= (wr_val == 8'h00);
            neg_q  <= wr_val[7];
        end
    end

    assign zero_flag = zero_q;
    assign neg_flag  = neg_q;
`else
    assign zero_flag = 1'b0;
    assign neg_flag  = 1'b0;
`endif

endmodule
